// File: rtl/mul_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32-step shift-add multiply, 32-step restoring divide.
// Optional macro FAST_MULT_EN: MULT/MULTU complete in one edge instead of the iterative path.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  md_op_e,
  input  logic [31:0] src_a_e,
  input  logic [31:0] src_b_e,
  input  logic        mf_d,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_stall
);

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  // Datapath: acc holds {upper, lower} product bits while multiplying and {rem, quo} while dividing.
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        neg_q, neg_d, sign_a_q, sign_a_d, is_div_q, is_div_d;

  logic        is_signed_op;
  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] prod_fix;
`ifdef FAST_MULT_EN
  logic [63:0] fast_prod;
`endif

  always_comb begin
    is_signed_op = (md_op_e == OP_MULT) || (md_op_e == OP_DIV);
    sign_a       = is_signed_op && src_a_e[31];
    sign_b       = is_signed_op && src_b_e[31];
    mag_a        = sign_a ? (~src_a_e + 32'd1) : src_a_e;
    mag_b        = sign_b ? (~src_b_e + 32'd1) : src_b_e;
`ifdef FAST_MULT_EN
    fast_prod    = {32'd0, mag_a} * {32'd0, mag_b};
    if (sign_a ^ sign_b) fast_prod = ~fast_prod + 64'd1;
`endif
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    prod_fix  = neg_q ? (~acc_q + 64'd1) : acc_q;
  end

  // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    is_div_d = is_div_q;

    unique case (state_q)
      S_IDLE: begin
        case (md_op_e)
          OP_MULT, OP_MULTU: begin
`ifdef FAST_MULT_EN
            {hi_d, lo_d} = fast_prod;
`else
            acc_d    = {32'd0, mag_b};
            opnd_d   = mag_a;
            neg_d    = sign_a ^ sign_b;
            sign_a_d = sign_a;
            is_div_d = 1'b0;
            cnt_d    = 6'd0;
            state_d  = S_MUL;
`endif
          end
          OP_DIV, OP_DIVU: begin
            acc_d    = {32'd0, mag_a};
            opnd_d   = mag_b;
            neg_d    = sign_a ^ sign_b;
            sign_a_d = sign_a;
            is_div_d = 1'b1;
            cnt_d    = 6'd0;
            state_d  = S_DIV;
          end
          OP_MTHI: hi_d = src_a_e;
          OP_MTLO: lo_d = src_a_e;
          default: ;
        endcase
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[31:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = S_FIX;
      end
      S_DIV: begin
        // A clear borrow bit means the shifted remainder covers the divisor.
        if (!div_diff[32]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
        else               acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          // With a zero divisor the remainder ends up as the dividend magnitude and the quotient as all ones.
          lo_d = (opnd_q == 32'd0) ? 32'hFFFF_FFFF
               : (neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0]);
          hi_d = sign_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        cnt_d   = 6'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // NOTE: datapath registers are left unreset; they are always loaded when an operation is accepted.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    opnd_q   <= opnd_d;
    neg_q    <= neg_d;
    sign_a_q <= sign_a_d;
    is_div_q <= is_div_d;
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != S_IDLE);
  assign md_stall = busy && (mf_d || (md_op_e != OP_NONE));

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized ops against an arithmetic model.
module tb_mul_div_unit;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
`ifdef FAST_MULT_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  md_op_e;
  logic [31:0] src_a_e, src_b_e;
  logic        mf_d;
  logic [31:0] hi, lo;
  logic        busy, md_stall;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  mul_div_unit dut (
    .clk(clk), .rst(rst), .md_op_e(md_op_e), .src_a_e(src_a_e), .src_b_e(src_b_e),
    .mf_d(mf_d), .hi(hi), .lo(lo), .busy(busy), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  // Architectural model: plain 64-bit arithmetic on the instruction semantics.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sq, sr;
    logic [63:0] p;
    case (op)
      OP_MULT:  begin sq = longint'($signed(a)) * longint'($signed(b)); p = sq; {m_hi, m_lo} = p; end
      OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
      OP_DIV: begin
        if (b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          m_lo = sq[31:0]; m_hi = sr[31:0];
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int exp_lat(input logic [2:0] op);
    if (op == OP_MULT || op == OP_MULTU) return MUL_LAT;
    if (op == OP_DIV || op == OP_DIVU) return DIV_LAT;
    return 0;
  endfunction

  // Present an op for exactly one edge, leaving time at #1 after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    md_op_e = op; src_a_e = a; src_b_e = b;
    @(posedge clk); #1;
    md_op_e = OP_NONE;
  endtask

  // Counts edges until busy drops, bounded so a stuck unit cannot hang the run.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy !== 1'b0 && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; md_op_e = OP_DIV; src_a_e = 32'h1234_5678; src_b_e = 32'd3; mf_d = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (hi !== 32'd0)      begin errors++; $display("FAIL reset_hi got=%h want=0", hi); end
    if (lo !== 32'd0)      begin errors++; $display("FAIL reset_lo got=%h want=0", lo); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", md_stall); end
    md_op_e = OP_NONE; mf_d = 1'b0; rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  ops [8] = '{OP_MULT, OP_MULTU, OP_MULT, OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU};
    logic [31:0] as  [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9,
                             32'd7, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF};
    logic [31:0] bs  [8] = '{32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2,
                             32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd16};
    int cyc;
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_idle(cyc);
      model(ops[i], as[i], bs[i]);
      checks += 3;
      if (cyc !== exp_lat(ops[i])) begin errors++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, cyc, exp_lat(ops[i])); end
      if (hi !== m_hi) begin errors++; $display("FAIL dir%0d_hi got=%h want=%h", i, hi, m_hi); end
      if (lo !== m_lo) begin errors++; $display("FAIL dir%0d_lo got=%h want=%h", i, lo, m_lo); end
    end
  endtask

  task automatic test_div_zero();
    logic [2:0]  ops [3] = '{OP_DIVU, OP_DIV, OP_DIV};
    logic [31:0] as  [3] = '{32'h0000_1234, 32'hFFFF_FFFB, 32'h8000_0000};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], 32'd0);
      wait_idle(cyc);
      checks += 3;
      if (cyc !== DIV_LAT)         begin errors++; $display("FAIL dz%0d_latency got=%0d want=%0d", i, cyc, DIV_LAT); end
      if (lo !== 32'hFFFF_FFFF)    begin errors++; $display("FAIL dz%0d_lo got=%h want=ffffffff", i, lo); end
      if (hi !== as[i])            begin errors++; $display("FAIL dz%0d_hi got=%h want=%h", i, hi, as[i]); end
      m_hi = as[i]; m_lo = 32'hFFFF_FFFF;
    end
  endtask

  task automatic test_mthi_mtlo();
    issue(OP_MTLO, 32'h0BAD_F00D, 32'd0);
    model(OP_MTLO, 32'h0BAD_F00D, 32'd0);
    checks += 3;
    if (lo !== m_lo)   begin errors++; $display("FAIL mtlo_lo got=%h want=%h", lo, m_lo); end
    if (hi !== m_hi)   begin errors++; $display("FAIL mtlo_hi_kept got=%h want=%h", hi, m_hi); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got=%b want=0", busy); end
    issue(OP_MTHI, 32'h1357_9BDF, 32'd0);
    model(OP_MTHI, 32'h1357_9BDF, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    checks += 2;
    if (hi !== m_hi) begin errors++; $display("FAIL hold_hi got=%h want=%h", hi, m_hi); end
    if (lo !== m_lo) begin errors++; $display("FAIL hold_lo got=%h want=%h", lo, m_lo); end
  endtask

  task automatic test_stall_ignore();
    logic [31:0] old_hi, old_lo;
    logic [2:0]  op;
    logic        want;
    int          cyc;
`ifdef FAST_MULT_EN
    op = OP_DIVU;
`else
    op = OP_MULTU;
`endif
    old_hi = m_hi; old_lo = m_lo;
    issue(op, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      mf_d    = (cyc >= 5);
      md_op_e = (cyc == 10 || cyc == 11) ? OP_MULT : OP_NONE;
      src_a_e = 32'd2; src_b_e = 32'd3;
      #1;
      want = (cyc >= 5) || (cyc == 10) || (cyc == 11);
      checks += 2;
      if (md_stall !== want) begin errors++; $display("FAIL stall_c%0d got=%b want=%b", cyc, md_stall, want); end
      if (hi !== old_hi || lo !== old_lo) begin
        errors++; $display("FAIL busy_hilo_c%0d got=%h_%h want=%h_%h", cyc, hi, lo, old_hi, old_lo);
      end
      @(posedge clk); #1;
      cyc++;
    end
    md_op_e = OP_NONE;
    #1;
    model(op, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks += 4;
    if (cyc !== 33)        begin errors++; $display("FAIL stall_latency got=%0d want=33", cyc); end
    if (md_stall !== 1'b0) begin errors++; $display("FAIL stall_after got=%b want=0", md_stall); end
    if (hi !== m_hi)       begin errors++; $display("FAIL stall_hi got=%h want=%h", hi, m_hi); end
    if (lo !== m_lo)       begin errors++; $display("FAIL stall_lo got=%h want=%h", lo, m_lo); end
    mf_d = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignored_op_started got=%b want=0", busy); end
  endtask

  task automatic test_reset_abort();
    int cyc;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    checks += 3;
    if (hi !== 32'd0)  begin errors++; $display("FAIL abort_hi got=%h want=0", hi); end
    if (lo !== 32'd0)  begin errors++; $display("FAIL abort_lo got=%h want=0", lo); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
    repeat (40) @(posedge clk);
    #1;
    checks += 2;
    if (hi !== 32'd0) begin errors++; $display("FAIL abort_late_hi got=%h want=0", hi); end
    if (lo !== 32'd0) begin errors++; $display("FAIL abort_late_lo got=%h want=0", lo); end
    issue(OP_MTHI, 32'hA5A5_A5A5, 32'd0);
    wait_idle(cyc);
    model(OP_MTHI, 32'hA5A5_A5A5, 32'd0);
    checks += 2;
    if (hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL post_mthi_hi got=%h want=a5a5a5a5", hi); end
    if (lo !== 32'd0)         begin errors++; $display("FAIL post_mthi_lo got=%h want=0", lo); end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    int          cyc;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(1, 6));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'($urandom_range(1, 15));
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      issue(op, a, b);
      wait_idle(cyc);
      model(op, a, b);
      checks += 3;
      if (cyc !== exp_lat(op)) begin errors++; $display("FAIL rnd%0d_latency op=%0d got=%0d want=%0d", i, op, cyc, exp_lat(op)); end
      if (hi !== m_hi) begin errors++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, hi, m_hi); end
      if (lo !== m_lo) begin errors++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, lo, m_lo); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_mthi_mtlo();
    test_stall_ignore();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: md_op_e  in  3  Execute-stage op: 000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NONE).
REQ-004 SHALL have: src_a_e  in  32  forwarded rs value (multiplicand/dividend/MTHI/MTLO source).
REQ-005 SHALL have: src_b_e  in  32  forwarded rt value (multiplier/divisor).
REQ-006 SHALL have: mf_d  in  1  mfhi/mflo present in Decode.
REQ-007 SHALL have: hi  out  32  and lo  out  32  architectural HI/LO registers.
REQ-008 SHALL have: busy  out  1  iterative operation in progress.
REQ-009 SHALL have: md_stall  out  1  request to Hazard_Unit to stall F/D and flush E.

Function
REQ-010 States SHALL be IDLE, MUL, DIV, FIX; ops accepted only in IDLE.
REQ-011 IDLE with MULT/MULTU/DIV/DIVU SHALL latch operand magnitudes and signs, clear 6-bit counter, go to MUL or DIV at the same edge.
REQ-012 MUL SHALL perform one shift-add step per cycle for 32 cycles, then go to FIX.
REQ-013 DIV SHALL perform one restoring-division step per cycle for 32 cycles, then go to FIX.
REQ-014 FIX SHALL apply sign correction, write hi/lo at its closing edge, return to IDLE.
REQ-015 busy SHALL be 1 in MUL, DIV, FIX: 33 cycles after the accepting edge; hi/lo valid the cycle busy falls.
REQ-016 MULT/MULTU SHALL give {hi,lo} = 64-bit signed/unsigned product.
REQ-017 DIV SHALL give lo = quotient truncated toward zero, hi = remainder with sign of dividend; DIVU unsigned.
REQ-018 Divisor 0 SHALL give lo = 32'hFFFFFFFF, hi = dividend, same 33-cycle latency.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000, hi = 0.
REQ-020 MTHI/MTLO in IDLE SHALL write hi/lo at the next edge, busy stays 0, other register unchanged.
REQ-021 Any md_op_e != NONE while busy SHALL be ignored (no state change); hi/lo SHALL NOT change outside FIX and MTHI/MTLO writes.
REQ-022 md_stall SHALL equal busy && (mf_d || md_op_e != NONE), combinational.
REQ-023 hi/lo SHALL hold their value indefinitely in IDLE with md_op_e = NONE.

Reset
REQ-024 rst high at an edge SHALL force state IDLE, counter 0, hi = 0, lo = 0, busy = 0, md_stall = 0 regardless of state.
REQ-025 Reset mid-operation SHALL abort it; no partial result SHALL reach hi/lo.

Configuration
REQ-026 Macro FAST_MULT_EN defined: MULT/MULTU SHALL write the full product into hi/lo at the accepting edge, never entering MUL/FIX, busy stays 0.
REQ-027 Macro FAST_MULT_EN undefined: MULT/MULTU SHALL use the 33-cycle iterative path; DIV/DIVU SHALL be 33 cycles in both builds.

Verification
REQ-028 MULT a=0xFFFFFFFE (-2), b=3 -> after 33 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA (with FAST_MULT_EN: next edge, busy never 1).
REQ-029 DIV a=0xFFFFFFF9 (-7), b=2 -> after 33 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
REQ-030 DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234 after 33 cycles.
REQ-031 MULTU 0xFFFFFFFF*0xFFFFFFFF then mf_d=1 on cycle 5 -> md_stall=1 until busy falls; second MULT during busy ignored; final hi=0xFFFFFFFE, lo=1.
REQ-032 DIV started, rst pulsed on cycle 10 -> hi=lo=0, busy=0 next cycle; subsequent MTHI 0xA5A5A5A5 -> hi=0xA5A5A5A5, lo=0.
